// File: rtl/fight_pkg.sv
// Shared encodings for the match sequencer: FSM states, winner codes and a
// ranking helper used for timeout and match decisions.
package fight_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned WIN_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        S_MENU       = 3'd0,
        S_COUNTDOWN  = 3'd1,
        S_PLAY       = 3'd2,
        S_ROUND_END  = 3'd3,
        S_MATCH_OVER = 3'd4
    } state_e;

    typedef enum logic [WIN_W-1:0] {
        WIN_NONE = 2'd0,
        WIN_P1   = 2'd1,
        WIN_P2   = 2'd2,
        WIN_DRAW = 2'd3
    } winner_e;

    function automatic winner_e rank_winner(input logic [15:0] a, input logic [15:0] b);
        if (a > b)      return WIN_P1;
        else if (b > a) return WIN_P2;
        else            return WIN_DRAW;
    endfunction

endpackage

// File: rtl/match_controller_if.sv
// Bus between the input/health logic, the match sequencer and the display
// drivers; the sequencer takes the slave side.
interface match_controller_if
    import fight_pkg::*;
#(
    parameter int unsigned HEALTH_W = 3
);
    logic                tick;
    logic                mode_sel;
    logic                start_btn;
    logic                pause_btn;
    logic [HEALTH_W-1:0] health1;
    logic [HEALTH_W-1:0] health2;

    logic [STATE_W-1:0]  state;
    logic                game_mode;
    logic                round_start;
    logic                round_over;
    logic [WIN_W-1:0]    round_winner;
    logic [WIN_W-1:0]    match_winner;
    logic [2:0]          p1_rounds;
    logic [2:0]          p2_rounds;
    logic [3:0]          countdown;
    logic [7:0]          time_left;
    logic                blink;
    logic                paused;

    modport master (
        output tick, mode_sel, start_btn, pause_btn, health1, health2,
        input  state, game_mode, round_start, round_over, round_winner, match_winner,
               p1_rounds, p2_rounds, countdown, time_left, blink, paused
    );

    modport slave (
        input  tick, mode_sel, start_btn, pause_btn, health1, health2,
        output state, game_mode, round_start, round_over, round_winner, match_winner,
               p1_rounds, p2_rounds, countdown, time_left, blink, paused
    );
endinterface

// File: rtl/sec_timer.sv
// Divides the tick enable into a one-cycle seconds strobe; clear_i restarts
// the sub-tick count and takes priority over counting.
module sec_timer #(
    parameter int unsigned TICKS_PER_SEC = 60
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_i,
    input  logic clear_i,
    output logic sec_o
);
    localparam int unsigned CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign sec_o = tick_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)     cnt_d = '0;
        else if (sec_o)  cnt_d = '0;
        else if (tick_i) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/match_controller.sv
// Best-of-N match sequencer: menu, countdown, timed rounds, round hold and
// match-over blink. Define PAUSE_EN to enable pausing during PLAY.
module match_controller
    import fight_pkg::*;
#(
    parameter int unsigned HEALTH_W      = 3,
    parameter int unsigned ROUNDS_TO_WIN = 2,
    parameter int unsigned MAX_ROUNDS    = 5,
    parameter int unsigned COUNT_START   = 3,
    parameter int unsigned TICKS_PER_SEC = 60,
    parameter int unsigned ROUND_TIME    = 99,
    parameter int unsigned END_HOLD_SEC  = 2,
    parameter int unsigned BLINK_TICKS   = 30
) (
    input logic               clk,
    input logic               rst,
    match_controller_if.slave bus
);
    state_e        state_q, state_d;
    logic          game_mode_q, game_mode_d;
    logic          round_start_q, round_start_d;
    logic          round_over_q, round_over_d;
    winner_e       round_winner_q, round_winner_d;
    winner_e       match_winner_q, match_winner_d;
    logic [2:0]    p1_q, p1_d, p2_q, p2_d, played_q, played_d;
    logic [3:0]    countdown_q, countdown_d;
    logic [7:0]    time_left_q, time_left_d;
    logic [7:0]    hold_q, hold_d;
    logic          blink_q, blink_d;
    logic [15:0]   blink_cnt_q, blink_cnt_d;
    logic          start_q, start_prev_q;

    logic          start_edge, frozen, tick_en, sec, state_chg;
    logic [HEALTH_W-1:0] h1, h2;
    winner_e       play_res;

    assign h1         = bus.health1;
    assign h2         = bus.health2;
    assign start_edge = start_q & ~start_prev_q;
    assign tick_en    = bus.tick & ~frozen;
    assign state_chg  = (state_d != state_q);

`ifdef PAUSE_EN
    logic paused_q, pause_q, pause_prev_q;

    assign frozen = paused_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            paused_q     <= 1'b0;
            pause_q      <= 1'b0;
            pause_prev_q <= 1'b0;
        end else begin
            pause_q      <= bus.pause_btn;
            pause_prev_q <= pause_q;
            if (state_d != S_PLAY)
                paused_q <= 1'b0;
            else if (state_q == S_PLAY && pause_q && !pause_prev_q)
                paused_q <= ~paused_q;
        end
    end

    assign bus.paused = paused_q;
`else
    assign frozen     = 1'b0;
    assign bus.paused = 1'b0;
`endif

    sec_timer #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_sec_timer (
        .clk     (clk),
        .rst     (rst),
        .tick_i  (tick_en),
        .clear_i (state_chg),
        .sec_o   (sec)
    );

    // KO takes precedence over the timeout comparison
    always_comb begin
        play_res = WIN_NONE;
        if (h1 == '0 && h2 == '0)  play_res = WIN_DRAW;
        else if (h1 == '0)         play_res = WIN_P2;
        else if (h2 == '0)         play_res = WIN_P1;
        else if (time_left_q == '0) play_res = rank_winner(16'(h1), 16'(h2));
    end

    always_comb begin
        state_d        = state_q;
        game_mode_d    = game_mode_q;
        round_start_d  = 1'b0;
        round_over_d   = 1'b0;
        round_winner_d = round_winner_q;
        match_winner_d = match_winner_q;
        p1_d           = p1_q;
        p2_d           = p2_q;
        played_d       = played_q;
        countdown_d    = countdown_q;
        time_left_d    = time_left_q;
        hold_d         = hold_q;
        blink_d        = blink_q;
        blink_cnt_d    = blink_cnt_q;

        case (state_q)
            S_MENU: begin
                game_mode_d = bus.mode_sel;
                if (start_edge) begin
                    state_d     = S_COUNTDOWN;
                    p1_d        = '0;
                    p2_d        = '0;
                    played_d    = '0;
                    countdown_d = 4'(COUNT_START);
                end
            end
            S_COUNTDOWN: begin
                if (sec) begin
                    if (countdown_q == '0) begin
                        state_d       = S_PLAY;
                        round_start_d = 1'b1;
                        time_left_d   = 8'(ROUND_TIME);
                    end else begin
                        countdown_d = countdown_q - 1'b1;
                    end
                end
            end
            S_PLAY: begin
                if (!frozen) begin
                    if (sec && time_left_q != '0)
                        time_left_d = time_left_q - 1'b1;
                    if (play_res != WIN_NONE) begin
                        state_d        = S_ROUND_END;
                        round_over_d   = 1'b1;
                        round_winner_d = play_res;
                        played_d       = played_q + 1'b1;
                        hold_d         = '0;
                        if (play_res == WIN_P1) p1_d = p1_q + 1'b1;
                        if (play_res == WIN_P2) p2_d = p2_q + 1'b1;
                    end
                end
            end
            S_ROUND_END: begin
                if (sec) begin
                    if (hold_q == 8'(END_HOLD_SEC - 1)) begin
                        if (p1_q == 3'(ROUNDS_TO_WIN) || p2_q == 3'(ROUNDS_TO_WIN) ||
                            played_q == 3'(MAX_ROUNDS)) begin
                            state_d        = S_MATCH_OVER;
                            match_winner_d = rank_winner(16'(p1_q), 16'(p2_q));
                            blink_cnt_d    = '0;
                        end else begin
                            state_d     = S_COUNTDOWN;
                            countdown_d = 4'(COUNT_START);
                        end
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            S_MATCH_OVER: begin
                if (bus.tick) begin
                    if (blink_cnt_q == 16'(BLINK_TICKS - 1)) begin
                        blink_d     = ~blink_q;
                        blink_cnt_d = '0;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 1'b1;
                    end
                end
                if (start_edge) begin
                    state_d        = S_MENU;
                    round_winner_d = WIN_NONE;
                    match_winner_d = WIN_NONE;
                    blink_d        = 1'b0;
                    blink_cnt_d    = '0;
                    p1_d           = '0;
                    p2_d           = '0;
                    played_d       = '0;
                end
            end
            default: state_d = S_MENU;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_MENU;
            game_mode_q    <= 1'b0;
            round_start_q  <= 1'b0;
            round_over_q   <= 1'b0;
            round_winner_q <= WIN_NONE;
            match_winner_q <= WIN_NONE;
            p1_q           <= '0;
            p2_q           <= '0;
            played_q       <= '0;
            countdown_q    <= 4'(COUNT_START);
            time_left_q    <= 8'(ROUND_TIME);
            hold_q         <= '0;
            blink_q        <= 1'b0;
            blink_cnt_q    <= '0;
            start_q        <= 1'b0;
            start_prev_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            game_mode_q    <= game_mode_d;
            round_start_q  <= round_start_d;
            round_over_q   <= round_over_d;
            round_winner_q <= round_winner_d;
            match_winner_q <= match_winner_d;
            p1_q           <= p1_d;
            p2_q           <= p2_d;
            played_q       <= played_d;
            countdown_q    <= countdown_d;
            time_left_q    <= time_left_d;
            hold_q         <= hold_d;
            blink_q        <= blink_d;
            blink_cnt_q    <= blink_cnt_d;
            start_q        <= bus.start_btn;
            start_prev_q   <= start_q;
        end
    end

    assign bus.state        = state_q;
    assign bus.game_mode    = game_mode_q;
    assign bus.round_start  = round_start_q;
    assign bus.round_over   = round_over_q;
    assign bus.round_winner = round_winner_q;
    assign bus.match_winner = match_winner_q;
    assign bus.p1_rounds    = p1_q;
    assign bus.p2_rounds    = p2_q;
    assign bus.countdown    = countdown_q;
    assign bus.time_left    = time_left_q;
    assign bus.blink        = blink_q;
endmodule

// File: tb/tb_match_controller.sv
// Scoreboard bench for match_controller: expected round results are queued
// when the deciding stimulus is driven and checked on each round_over pulse.
module tb_match_controller;
    import fight_pkg::*;

    localparam int unsigned TPS = 4;
    localparam int unsigned RT  = 6;
    localparam int unsigned CS  = 3;

    typedef struct packed {
        logic [1:0] w;
        logic [2:0] p1;
        logic [2:0] p2;
    } rnd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   spurious = 0;
    int   overs    = 0;
    rnd_t sb[$];
    rnd_t exp_r;

    match_controller_if #(.HEALTH_W(3)) bus ();

    match_controller #(
        .HEALTH_W      (3),
        .ROUNDS_TO_WIN (2),
        .MAX_ROUNDS    (5),
        .COUNT_START   (CS),
        .TICKS_PER_SEC (TPS),
        .ROUND_TIME    (RT),
        .END_HOLD_SEC  (2),
        .BLINK_TICKS   (30)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) bus.tick = 1'b1;
            @(negedge clk) bus.tick = 1'b0;
        end
    endtask

    task automatic press_start();
        @(negedge clk) bus.start_btn = 1'b1;
        @(negedge clk) bus.start_btn = 1'b0;
        @(negedge clk);
    endtask

    task automatic press_pause();
        @(negedge clk) bus.pause_btn = 1'b1;
        @(negedge clk) bus.pause_btn = 1'b0;
        @(negedge clk);
    endtask

    task automatic finish_round();
        @(negedge clk);
        @(negedge clk);
        check("round_over_width", 32'(bus.round_over), 0);
        check("round_end_state", 32'(bus.state), 32'(S_ROUND_END));
        bus.health1 = 3'd5;
        bus.health2 = 3'd5;
    endtask

    task automatic next_round();
        tick_n(7);
        check("hold_state", 32'(bus.state), 32'(S_ROUND_END));
        tick_n(1);
        check("recount_state", 32'(bus.state), 32'(S_COUNTDOWN));
        check("recount_digit", 32'(bus.countdown), CS);
        tick_n(16);
        check("replay_state", 32'(bus.state), 32'(S_PLAY));
        check("replay_time", 32'(bus.time_left), RT);
    endtask

    task automatic run_timeout();
        tick_n(23);
        check("time_one", 32'(bus.time_left), 1);
        check("time_one_state", 32'(bus.state), 32'(S_PLAY));
        tick_n(1);
        check("time_zero", 32'(bus.time_left), 0);
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_state"}, 32'(bus.state), 32'(S_MENU));
        check({pfx, "_countdown"}, 32'(bus.countdown), CS);
        check({pfx, "_time_left"}, 32'(bus.time_left), RT);
        check({pfx, "_game_mode"}, 32'(bus.game_mode), 0);
        check({pfx, "_round_start"}, 32'(bus.round_start), 0);
        check({pfx, "_round_over"}, 32'(bus.round_over), 0);
        check({pfx, "_round_winner"}, 32'(bus.round_winner), 0);
        check({pfx, "_match_winner"}, 32'(bus.match_winner), 0);
        check({pfx, "_p1_rounds"}, 32'(bus.p1_rounds), 0);
        check({pfx, "_p2_rounds"}, 32'(bus.p2_rounds), 0);
        check({pfx, "_blink"}, 32'(bus.blink), 0);
        check({pfx, "_paused"}, 32'(bus.paused), 0);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.round_over) begin
            overs++;
            if (sb.size() == 0) begin
                spurious++;
            end else begin
                exp_r = sb.pop_front();
                check("sb_winner", 32'(bus.round_winner), 32'(exp_r.w));
                check("sb_p1_rounds", 32'(bus.p1_rounds), 32'(exp_r.p1));
                check("sb_p2_rounds", 32'(bus.p2_rounds), 32'(exp_r.p2));
                check("sb_state", 32'(bus.state), 32'(S_ROUND_END));
            end
        end
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        bus.tick      = 1'b0;
        bus.mode_sel  = 1'b1;
        bus.start_btn = 1'b0;
        bus.pause_btn = 1'b0;
        bus.health1   = 3'd5;
        bus.health2   = 3'd5;
        repeat (3) @(negedge clk);
        check_reset("por");
        rst = 1'b0;
        @(negedge clk);
        check("menu_mode_follow", 32'(bus.game_mode), 1);

        press_start();
        check("cd_entry_state", 32'(bus.state), 32'(S_COUNTDOWN));
        check("cd_entry_digit", 32'(bus.countdown), CS);
        bus.mode_sel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick_n(4);
            check("cd_digit", 32'(bus.countdown), 32'(2 - i));
        end
        tick_n(3);
        check("cd_hold_state", 32'(bus.state), 32'(S_COUNTDOWN));
        check("cd_no_start", 32'(bus.round_start), 0);
        tick_n(1);
        check("play_state", 32'(bus.state), 32'(S_PLAY));
        check("round_start_pulse", 32'(bus.round_start), 1);
        check("play_time", 32'(bus.time_left), RT);
        check("mode_latched", 32'(bus.game_mode), 1);
        @(negedge clk);
        check("round_start_width", 32'(bus.round_start), 0);

`ifdef PAUSE_EN
        tick_n(2);
        press_pause();
        check("paused_on", 32'(bus.paused), 1);
        tick_n(20);
        check("paused_time_frozen", 32'(bus.time_left), RT);
        check("paused_state", 32'(bus.state), 32'(S_PLAY));
        press_pause();
        check("paused_off", 32'(bus.paused), 0);
        tick_n(2);
        check("resume_time", 32'(bus.time_left), RT - 1);
`else
        press_pause();
        check("pause_ignored", 32'(bus.paused), 0);
        check("pause_state", 32'(bus.state), 32'(S_PLAY));
`endif

        // round 1: P2 knocked out
        sb.push_back('{w: WIN_P1, p1: 3'd1, p2: 3'd0});
        bus.health2 = 3'd0;
        finish_round();

        // round 2: timeout with equal health
        next_round();
        sb.push_back('{w: WIN_DRAW, p1: 3'd1, p2: 3'd0});
        run_timeout();
        finish_round();

        // round 3: double KO in the same cycle the clock runs out
        bus.health1 = 3'd5;
        bus.health2 = 3'd3;
        next_round();
        sb.push_back('{w: WIN_DRAW, p1: 3'd1, p2: 3'd0});
        run_timeout();
        bus.health1 = 3'd0;
        bus.health2 = 3'd0;
        finish_round();

        // round 4: timeout, P1 ahead on health
        bus.health1 = 3'd5;
        bus.health2 = 3'd3;
        next_round();
        sb.push_back('{w: WIN_P1, p1: 3'd2, p2: 3'd0});
        run_timeout();
        finish_round();

        tick_n(7);
        check("final_hold", 32'(bus.state), 32'(S_ROUND_END));
        tick_n(1);
        check("match_over_state", 32'(bus.state), 32'(S_MATCH_OVER));
        check("match_winner", 32'(bus.match_winner), 32'(WIN_P1));
        check("match_blink_init", 32'(bus.blink), 0);
        tick_n(29);
        check("blink_pre_toggle", 32'(bus.blink), 0);
        tick_n(1);
        check("blink_toggle1", 32'(bus.blink), 1);
        tick_n(29);
        check("blink_hold", 32'(bus.blink), 1);
        tick_n(1);
        check("blink_toggle2", 32'(bus.blink), 0);

        press_start();
        check("menu_state", 32'(bus.state), 32'(S_MENU));
        check("menu_round_winner", 32'(bus.round_winner), 0);
        check("menu_match_winner", 32'(bus.match_winner), 0);
        check("menu_p1_rounds", 32'(bus.p1_rounds), 0);
        check("menu_p2_rounds", 32'(bus.p2_rounds), 0);

        bus.mode_sel = 1'b1;
        press_start();
        tick_n(5);
        check("mid_cd_digit", 32'(bus.countdown), 2);
        check("mid_cd_mode", 32'(bus.game_mode), 1);
        @(negedge clk) rst = 1'b1;
        #1;
        check_reset("async");
        @(negedge clk) rst = 1'b0;

        check("no_spurious_round_over", 32'(spurious), 0);
        check("round_over_count", 32'(overs), 4);
        check("scoreboard_drained", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/match_controller.md
Name: match_controller

Overview:
Parametrised next-generation match sequencer for the fight game. It adds best-of-N rounds, a per-round seconds timer, health-based timeout decisions and configurable tick-rate timing. It sits between the input/health logic and the display/LED drivers. All timing is derived from a single-cycle tick enable (the 60 Hz or KEY strobe), not from clk directly.

Parameters:
HEALTH_W, 3, width of each player health input
ROUNDS_TO_WIN, 2, round wins needed to take the match
MAX_ROUNDS, 5, total rounds played before a forced match end
COUNT_START, 3, first countdown digit shown
TICKS_PER_SEC, 60, tick pulses per second
ROUND_TIME, 99, round length in seconds (max 255)
END_HOLD_SEC, 2, seconds spent in ROUND_END
BLINK_TICKS, 30, ticks per blink half-period

Ports:
clk  in  1  system clock
rst  in  1  reset
tick  in  1  timing enable; one clk cycle wide
mode_sel  in  1  0 = 1P, 1 = 2P
start_btn  in  1  start/confirm level; edge-detected internally
pause_btn  in  1  pause level; edge-detected internally, used only with PAUSE_EN
health1  in  HEALTH_W  P1 health
health2  in  HEALTH_W  P2 health
state  out  3  MENU=0, COUNTDOWN=1, PLAY=2, ROUND_END=3, MATCH_OVER=4
game_mode  out  1  mode latched at match start
round_start  out  1  one-cycle pulse on entering PLAY
round_over  out  1  one-cycle pulse on leaving PLAY
round_winner  out  2  0 none, 1 P1, 2 P2, 3 draw
match_winner  out  2  same encoding; valid in MATCH_OVER
p1_rounds  out  3  P1 round wins
p2_rounds  out  3  P2 round wins
countdown  out  4  current countdown digit
time_left  out  8  seconds remaining, binary
blink  out  1  MATCH_OVER blink phase
paused  out  1  pause active

Behaviour:
Interface:
- Reset rst, asynchronous, active-high; clock clk.
- Reset values: state=MENU; countdown=COUNT_START; time_left=ROUND_TIME; all other outputs and internal counters 0.

Timing:
- A second elapses on the tick at which the sub-tick counter equals TICKS_PER_SEC-1. The counter then clears.
- The sub-tick counter clears on every state entry.
- Button edge = rising edge of the registered level. An edge held across a state change is not reused.

MENU:
- game_mode follows mode_sel.
- start edge -> COUNTDOWN. On that transition: latch game_mode, clear p1_rounds, p2_rounds and the rounds-played counter, set countdown=COUNT_START.

COUNTDOWN:
- On each second, countdown decrements.
- On the second at which countdown==0: go to PLAY, pulse round_start, load time_left=ROUND_TIME.

PLAY:
- KO is evaluated every clk, not gated by tick.
- Resolution:
  - Both health==0 -> draw.
  - health1==0 -> P2.
  - health2==0 -> P1.
  - Otherwise, when time_left==0: higher health wins, equal health -> draw.
- time_left decrements on each second and saturates at 0.
- KO and timeout in the same cycle -> KO decides.
- On resolution: pulse round_over, write round_winner, increment the winner's round count (draws add nothing), increment rounds played, go to ROUND_END.

ROUND_END:
- After END_HOLD_SEC seconds:
  - If either round count==ROUNDS_TO_WIN, or rounds played==MAX_ROUNDS -> MATCH_OVER.
  - Otherwise -> COUNTDOWN with countdown=COUNT_START.

MATCH_OVER:
- match_winner = player with more rounds; equal -> 3.
- blink toggles every BLINK_TICKS ticks.
- start edge -> MENU, clearing round_winner, match_winner and blink.

General:
- rst at any point returns to reset values immediately.
- Unused state encodings -> MENU.

Optional Feature:
PAUSE_EN
- Defined: in PLAY, a pause_btn edge toggles paused. While paused, the sub-tick counter, time_left and KO evaluation are frozen. paused clears on leaving PLAY.
- Undefined: pause_btn is ignored and paused is tied to 0.

Decomposition:
- Package fight_pkg holds: state encodings, winner codes (NONE/P1/P2/DRAW), and the widths 3 (state) and 2 (winner).
- Sub-module sec_timer: tick in, clear in, one-cycle sec strobe out, parameter TICKS_PER_SEC.
- Edge detectors remain inline.

Test Plan:
- TICKS_PER_SEC=4, start edge in MENU with mode_sel=1 -> game_mode=1; countdown 3,2,1,0 at 4-tick intervals; round_start pulses 16 ticks after entry.
- In PLAY, health2 driven to 0 -> round_winner=1, p1_rounds=1, round_over pulses one cycle, state=ROUND_END.
- Run time_left to 0 with health1=5, health2=3 -> P1 wins the round. Repeat with equal health -> draw, both round counts unchanged.
- Both health at 0 while time_left==0 in the same cycle -> draw; the KO path is taken.
- P1 wins two rounds -> MATCH_OVER, match_winner=1, blink toggles every 30 ticks; start edge -> MENU with counts cleared.
- rst asserted mid-COUNTDOWN -> all outputs at reset values in the same cycle. With PAUSE_EN, a pause edge in PLAY freezes time_left for 20 ticks.
